// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle, shift-add multiply, restoring divide.
// Define MULDIV_EARLY_OUT_EN to let divide-by-zero and zero-operand multiplies skip the iteration.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  input  logic            i_flush,
  output logic            o_ready,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [2:0]          funct3_r;
  logic                neg_r;
  logic [XLEN-1:0]     b_mag;
  logic [2*XLEN-1:0]   acc, acc_nxt;
  logic [XLEN-1:0]     result_r;

  logic                accept, last_iter, early_hit, neg_in;
  logic                a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]     a_mag_in, b_mag_in, early_res;
  logic [XLEN:0]       mul_sum, rem_sh, diff;

  // Apply the sign recorded at accept time and pick the half/word the op returns.
  function automatic logic [XLEN-1:0] finalize(input logic [2:0] f3, input logic neg,
                                               input logic [2*XLEN-1:0] raw);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   q, r;
    prod = neg ? -raw : raw;
    q    = raw[XLEN-1:0];
    r    = raw[2*XLEN-1:XLEN];
    if (!f3[2])      finalize = (f3[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else if (!f3[1]) finalize = neg ? -q : q;
    else             finalize = neg ? -r : r;
  endfunction

  assign accept    = (state == IDLE) && i_valid && !i_flush;
  assign last_iter = (state == BUSY) && (cnt == CNT_W'(XLEN - 1));

  assign a_signed = (i_funct3 != 3'b011) && (i_funct3 != 3'b101) && (i_funct3 != 3'b111);
  assign b_signed = a_signed && (i_funct3 != 3'b010);
  assign a_neg    = a_signed && i_op_a[XLEN-1];
  assign b_neg    = b_signed && i_op_b[XLEN-1];
  assign a_mag_in = a_neg ? -i_op_a : i_op_a;
  assign b_mag_in = b_neg ? -i_op_b : i_op_b;

  // Quotient is left positive on divide-by-zero so DIV returns all-ones.
  always_comb begin
    if (!i_funct3[2])      neg_in = a_neg ^ b_neg;
    else if (!i_funct3[1]) neg_in = (a_neg ^ b_neg) && (i_op_b != '0);
    else                   neg_in = a_neg;
  end

`ifdef MULDIV_EARLY_OUT_EN
  assign early_hit = i_funct3[2] ? (i_op_b == '0) : ((i_op_a == '0) || (i_op_b == '0));
`else
  assign early_hit = 1'b0;
`endif
  assign early_res = !i_funct3[2] ? '0 : (i_funct3[1] ? i_op_a : '1);

  // acc = {hi, lo}: multiply keeps the multiplier in lo, divide shifts the dividend out of lo.
  always_comb begin
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_mag} : '0);
    rem_sh  = acc[2*XLEN-1:XLEN-1];
    diff    = rem_sh - {1'b0, b_mag};
    if (!funct3_r[2])   acc_nxt = {mul_sum, acc[XLEN-1:1]};
    else if (!diff[XLEN]) acc_nxt = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else                acc_nxt = {acc[2*XLEN-2:0], 1'b0};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = early_hit ? DONE : BUSY;
      BUSY:    if (i_flush) state_nxt = IDLE;
               else if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_ready = (state == IDLE);
    o_valid = (state == DONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt      <= '0;
      funct3_r <= '0;
      neg_r    <= 1'b0;
      b_mag    <= '0;
      acc      <= '0;
      result_r <= '0;
    end else if (accept) begin
      cnt      <= '0;
      funct3_r <= i_funct3;
      neg_r    <= neg_in;
      b_mag    <= b_mag_in;
      acc      <= {{XLEN{1'b0}}, a_mag_in};
      if (early_hit) result_r <= early_res;
    end else if ((state == BUSY) && !i_flush) begin
      cnt <= cnt + CNT_W'(1);
      acc <= acc_nxt;
      if (last_iter) result_r <= finalize(funct3_r, neg_r, acc_nxt);
    end
  end

  assign o_result = result_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected results and due cycles queued at issue, checked by a monitor.
module tb_muldiv_unit;
  localparam int XLEN = 32;

  logic            i_clk = 1'b0;
  logic            i_rst, i_valid, i_flush;
  logic [2:0]      i_funct3;
  logic [XLEN-1:0] i_op_a, i_op_b;
  logic            o_ready, o_valid;
  logic [XLEN-1:0] o_result;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_funct3(i_funct3),
    .i_op_a(i_op_a), .i_op_b(i_op_b), .i_flush(i_flush),
    .o_ready(o_ready), .o_valid(o_valid), .o_result(o_result)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a, b, res;
    int          due;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  // Reference: plain 64-bit arithmetic plus the RISC-V corner-case rules.
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb_, ua, ub;
    logic [63:0] p;
    sa = $signed(a); sb_ = $signed(b);
    ua = {32'd0, a}; ub = {32'd0, b};
    case (f3)
      3'd0: begin p = sa * sb_; return p[31:0]; end
      3'd1: begin p = sa * sb_; return p[63:32]; end
      3'd2: begin p = sa * ub;  return p[63:32]; end
      3'd3: begin p = ua * ub;  return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb_; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb_; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    if (f3[2] ? (b == 0) : (a == 0 || b == 0)) return 1;
`endif
    return XLEN + 1 + 0 * int'(a[0] ^ b[0] ^ f3[0]);
  endfunction

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return $urandom_range(0, 15);
      default: return $urandom();
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Present a request from a negedge and hold it until accepted; leaves i_valid high.
  task automatic issue_x(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] want);
    exp_t e;
    int n;
    i_valid = 1'b1; i_funct3 = f3; i_op_a = a; i_op_b = b;
    n = 0;
    while (!o_ready && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_ready) begin
      checks++; errors++;
      $display("FAIL issue_timeout: o_ready stayed 0, want 1 (cycle %0d)", cyc);
    end else begin
      e.f3 = f3; e.a = a; e.b = b; e.res = want;
      e.due = cyc + latency(f3, a, b);
      sb.push_back(e);
    end
    @(negedge i_clk);
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    issue_x(f3, a, b, ref_model(f3, a, b));
  endtask

  task automatic drain();
    int n;
    i_valid = 1'b0;
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    if (sb.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d results outstanding, want 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge i_clk);
  endtask

  // Monitor: every o_valid must match the oldest outstanding request, on its due cycle.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL spurious_valid: o_valid=1 result %h, want o_valid=0 (cycle %0d)", o_result, cyc);
        end else begin
          mon_e = sb.pop_front();
          if (o_result !== mon_e.res || cyc != mon_e.due) begin
            errors++;
            $display("FAIL result f3=%0d a=%h b=%h: got %h at cycle %0d, want %h at cycle %0d",
                     mon_e.f3, mon_e.a, mon_e.b, o_result, cyc, mon_e.res, mon_e.due);
          end
        end
      end else if (sb.size() > 0 && cyc > sb[0].due) begin
        checks++; errors++;
        mon_e = sb.pop_front();
        $display("FAIL missing_valid f3=%0d a=%h b=%h: no o_valid by cycle %0d, want %h",
                 mon_e.f3, mon_e.a, mon_e.b, mon_e.due, mon_e.res);
      end
    end
  end

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0;
    i_funct3 = 3'd0; i_op_a = '0; i_op_b = '0;
    repeat (3) @(negedge i_clk);
    check("reset_ready", {31'd0, o_ready}, 32'd1);
    check("reset_valid", {31'd0, o_valid}, 32'd0);
    check("reset_result", o_result, 32'd0);
    i_rst = 1'b0;
    @(negedge i_clk);

    // Directed values with independently known answers.
    issue_x(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    issue_x(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    issue_x(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    issue_x(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue_x(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    issue_x(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    issue_x(3'd5, 32'd100, 32'd7, 32'd14);
    issue_x(3'd7, 32'd100, 32'd7, 32'd2);
    issue_x(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF);
    issue_x(3'd6, 32'd5, 32'd0, 32'd5);
    issue_x(3'd4, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
    issue_x(3'd6, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);
    issue_x(3'd5, 32'd9, 32'd0, 32'hFFFF_FFFF);
    issue_x(3'd7, 32'd9, 32'd0, 32'd9);
    issue_x(3'd0, 32'd0, 32'd9, 32'd0);
    issue_x(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    issue_x(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
    drain();

    // Flush mid-divide, then a fresh multiply two cycles later.
    issue(3'd5, 32'hDEAD_BEEF, 32'd13);
    repeat (9) @(negedge i_clk);
    i_flush = 1'b1; i_valid = 1'b0;
    void'(sb.pop_back());
    @(negedge i_clk);
    i_flush = 1'b0;
    check("flush_ready", {31'd0, o_ready}, 32'd1);
    @(negedge i_clk);
    issue_x(3'd0, 32'd3, 32'd4, 32'd12);
    drain();

    // Flush while idle must block acceptance.
    i_valid = 1'b1; i_flush = 1'b1; i_funct3 = 3'd0; i_op_a = 32'd5; i_op_b = 32'd6;
    @(negedge i_clk);
    check("flush_idle_block", {31'd0, o_ready}, 32'd1);
    i_valid = 1'b0; i_flush = 1'b0;
    repeat (3) @(negedge i_clk);

    // Reset mid-MULHU with i_valid held high throughout.
    issue(3'd3, 32'hFFFF_FFFF, 32'h1234_5678);
    for (int k = 0; k < 19; k++) begin
      if (k % 6 == 0) check("busy_not_ready", {31'd0, o_ready}, 32'd0);
      @(negedge i_clk);
    end
    i_rst = 1'b1; i_valid = 1'b0;
    sb.delete();
    @(negedge i_clk);
    check("abort_ready", {31'd0, o_ready}, 32'd1);
    check("abort_valid", {31'd0, o_valid}, 32'd0);
    check("abort_result", o_result, 32'd0);
    i_rst = 1'b0;
    @(negedge i_clk);

    // Randomized traffic against the reference model.
    for (int t = 0; t < 60; t++) begin
      issue(3'($urandom_range(0, 7)), rnd_op(), rnd_op());
      if ($urandom_range(0, 3) == 0) begin
        i_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge i_clk);
      end
    end
    drain();

    repeat (5) @(negedge i_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
